// File: rtl/dcache_writeback_tx.sv
// dcache_writeback_tx: serializes one dirty 128-bit cache line into four 32-bit memory write beats
module dcache_writeback_tx #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [127:0]      wb_line,
    output logic              wb_ready,
    output logic              wb_done,
    output logic              mem_wvalid,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wready
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-5:0] base_q, base_d;
    logic [127:0]      buf_q, buf_d;
    logic [1:0]        beat_q, beat_d;
    // next state: latch a line when idle, step through beats on each accepted handshake
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        buf_d   = buf_q;
        beat_d  = beat_q;
        if (state_q == IDLE && wb_req) begin
            state_d = SEND;
            base_d  = wb_addr[ADDR_W-1:4];
            buf_d   = wb_line;
            beat_d  = 2'd0;
        end else if (state_q == SEND && mem_wready) begin
            state_d = beat_q == 2'd3 ? DONE : SEND;
            beat_d  = beat_q == 2'd3 ? beat_q : beat_q + 2'd1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // outputs decode registered state only, so there is no input-to-output path
    always_comb begin
        wb_ready   = state_q == IDLE;
        wb_done    = state_q == DONE;
        mem_wvalid = state_q == SEND;
        mem_waddr  = {base_q, beat_q, 2'b00};
        mem_wdata  = buf_q[{beat_q, 5'b0} +: 32];
    end
    // state register; reset abandons any line in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            buf_q   <= '0;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
            beat_q  <= beat_d;
        end
    end
endmodule
